// File: rtl/data_mem_if.sv
// Load/store request/response bundle between the core memory stage and the data memory responder.
interface data_mem_if;
    logic        req_valid;
    logic        req_ready;
    logic        mem_read;
    logic        mem_write;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, mem_read, mem_write, funct3, addr, wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, mem_read, mem_write, funct3, addr, wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/data_mem_responder.sv
// Single-outstanding data memory with programmable response latency, RISC-V load extension,
// byte-lane stores and fault flagging.
module data_mem_responder #(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned DEPTH   = 256,
    parameter int unsigned LATENCY = 2
) (
    input  logic       clk,
    input  logic       reset,
    data_mem_if.slave  bus
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(LATENCY) + 1;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

    state_e              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                rd_q, rd_d, wr_q, wr_d;
    logic [2:0]          f3_q, f3_d;
    logic [31:0]         addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                rsp_err_q, rsp_err_d;
    logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;

    logic [DATA_W-1:0]   mem [DEPTH];
    logic [AW-1:0]       widx;
    logic [DATA_W-1:0]   rword, store_word, load_ext;
    logic [7:0]          rbyte;
    logic [15:0]         rhalf;
    logic                is_load, is_store, f3_err, mis_err, rng_err, err_c;
    logic                accept, commit, mem_we;

    assign widx   = addr_q[AW+1:2];
    assign rword  = mem[widx];
    assign accept = (state_q == IDLE) && bus.req_valid && !reset;
    assign commit = (state_q == WAIT) && (cnt_q == '0);

    assign bus.req_ready = (state_q == IDLE) && !reset;
    assign bus.rsp_valid = (state_q == RESP);
    assign bus.rsp_err   = rsp_err_q;
    assign bus.rsp_rdata = rsp_rdata_q;

    // State register plus captured request and response registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            rd_q        <= 1'b0;
            wr_q        <= 1'b0;
            f3_q        <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rd_q        <= rd_d;
            wr_q        <= wr_d;
            f3_q        <= f3_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    // Storage array is deliberately not reset.
    always_ff @(posedge clk) begin
        if (mem_we) mem[widx] <= store_word;
    end

    // Next-state and latency counter.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: if (accept) begin
                state_d = WAIT;
                cnt_d   = CW'(LATENCY - 1);
            end
            WAIT: if (cnt_q == '0) state_d = RESP;
                  else cnt_d = cnt_q - CW'(1);
            RESP: if (bus.rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Request decode, lane extraction and store merge from the captured request.
    always_comb begin
        is_load  = rd_q && !wr_q;
        is_store = wr_q && !rd_q;
        f3_err   = 1'b0;
        if (is_load)
            f3_err = !(f3_q inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
        else if (is_store)
            f3_err = !(f3_q inside {3'b000, 3'b001, 3'b010});
        mis_err = ((f3_q[1:0] == 2'b01) && addr_q[0]) ||
                  ((f3_q[1:0] == 2'b10) && (addr_q[1:0] != 2'b00));
        rng_err = (addr_q[31:2] >= 30'(DEPTH));
        err_c   = (rd_q == wr_q) || f3_err || mis_err || rng_err;

        case (addr_q[1:0])
            2'd0:    rbyte = rword[7:0];
            2'd1:    rbyte = rword[15:8];
            2'd2:    rbyte = rword[23:16];
            default: rbyte = rword[31:24];
        endcase
        rhalf = addr_q[1] ? rword[31:16] : rword[15:0];

        case (f3_q)
            3'b000:  load_ext = {{24{rbyte[7]}}, rbyte};
            3'b001:  load_ext = {{16{rhalf[15]}}, rhalf};
            3'b010:  load_ext = rword;
            3'b100:  load_ext = {24'd0, rbyte};
            3'b101:  load_ext = {16'd0, rhalf};
            default: load_ext = '0;
        endcase

        store_word = rword;
        case (f3_q)
            3'b000:  store_word[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
            3'b001:  store_word[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
            3'b010:  store_word = wdata_q;
            default: store_word = rword;
        endcase
    end

    // Capture, commit and response register updates.
    always_comb begin
        rd_d        = rd_q;
        wr_d        = wr_q;
        f3_d        = f3_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rsp_err_d   = rsp_err_q;
        rsp_rdata_d = rsp_rdata_q;
        mem_we      = 1'b0;
        if (accept) begin
            rd_d    = bus.mem_read;
            wr_d    = bus.mem_write;
            f3_d    = bus.funct3;
            addr_d  = bus.addr;
            wdata_d = bus.wdata;
        end
        if (commit) begin
            rsp_err_d   = err_c;
            rsp_rdata_d = (!err_c && is_load) ? load_ext : '0;
            mem_we      = !err_c && is_store && !reset;
        end
        if ((state_q == RESP) && bus.rsp_ready) begin
            rsp_err_d   = 1'b0;
            rsp_rdata_d = '0;
        end
    end
endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench: three responders (latency 2, 4, 1) share stimulus, selected by sel.
module tb_data_mem_responder;
    logic        clk;
    logic        reset;
    logic [1:0]  sel;
    logic        req_valid, mem_read, mem_write, rsp_ready;
    logic [2:0]  funct3;
    logic [31:0] addr, wdata;
    logic        req_ready, rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;
    int          n_checks, n_fail;

    data_mem_if if2 ();
    data_mem_if if4 ();
    data_mem_if if1 ();

    data_mem_responder #(.DATA_W(32), .DEPTH(256), .LATENCY(2)) u_l2 (.clk(clk), .reset(reset), .bus(if2));
    data_mem_responder #(.DATA_W(32), .DEPTH(256), .LATENCY(4)) u_l4 (.clk(clk), .reset(reset), .bus(if4));
    data_mem_responder #(.DATA_W(32), .DEPTH(256), .LATENCY(1)) u_l1 (.clk(clk), .reset(reset), .bus(if1));

    assign if2.req_valid = req_valid && (sel == 2'd0);
    assign if4.req_valid = req_valid && (sel == 2'd1);
    assign if1.req_valid = req_valid && (sel == 2'd2);
    assign {if2.mem_read, if2.mem_write, if2.funct3, if2.addr, if2.wdata, if2.rsp_ready} =
           {mem_read, mem_write, funct3, addr, wdata, rsp_ready};
    assign {if4.mem_read, if4.mem_write, if4.funct3, if4.addr, if4.wdata, if4.rsp_ready} =
           {mem_read, mem_write, funct3, addr, wdata, rsp_ready};
    assign {if1.mem_read, if1.mem_write, if1.funct3, if1.addr, if1.wdata, if1.rsp_ready} =
           {mem_read, mem_write, funct3, addr, wdata, rsp_ready};

    always_comb begin
        case (sel)
            2'd1:    {req_ready, rsp_valid, rsp_err, rsp_rdata} = {if4.req_ready, if4.rsp_valid, if4.rsp_err, if4.rsp_rdata};
            2'd2:    {req_ready, rsp_valid, rsp_err, rsp_rdata} = {if1.req_ready, if1.rsp_valid, if1.rsp_err, if1.rsp_rdata};
            default: {req_ready, rsp_valid, rsp_err, rsp_rdata} = {if2.req_ready, if2.rsp_valid, if2.rsp_err, if2.rsp_rdata};
        endcase
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    // One full request/response; called and returning #1 after a rising edge, rsp_ready held 1.
    task automatic xact(input logic [1:0] s, input logic rd, input logic wr, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd,
                        output int lat, output logic [31:0] rdata, output logic err, output time t_acc);
        int n;
        sel = s; mem_read = rd; mem_write = wr; funct3 = f3; addr = a; wdata = wd;
        rsp_ready = 1'b1;
        req_valid = 1'b1;
        n = 0;
        while (!req_ready && n < 20) begin
            @(posedge clk); #1; n++;
        end
        @(posedge clk);
        t_acc = $time;
        #1;
        req_valid = 1'b0;
        n = 0;
        while (!rsp_valid && n < 20) begin
            @(posedge clk); #1; n++;
        end
        lat   = n;
        rdata = rsp_rdata;
        err   = rsp_err;
        @(posedge clk); #1;
    endtask

    int          lat;
    logic [31:0] rd_v;
    logic        er_v;
    time         t0, t1, t2;
    logic        seen;

    initial begin
        n_checks = 0; n_fail = 0;
        sel = 0; req_valid = 0; mem_read = 0; mem_write = 0; funct3 = 0;
        addr = 0; wdata = 0; rsp_ready = 1;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_err",   32'(rsp_err),   32'd0);
        check("rst_rsp_rdata", rsp_rdata,      32'd0);
        reset = 1'b0;
        @(posedge clk); #1;
        check("idle_req_ready", 32'(req_ready), 32'd1);

        // Latency 2 instance: store/load, lane extension, faults.
        xact(0, 0, 1, 3'b010, 32'h10, 32'hDEADBEEF, lat, rd_v, er_v, t0);
        check("sw_lat", 32'(lat), 32'd2);
        check("sw_err", 32'(er_v), 32'd0);
        check("sw_rdata", rd_v, 32'd0);
        xact(0, 1, 0, 3'b010, 32'h10, 32'h0, lat, rd_v, er_v, t0);
        check("lw_lat", 32'(lat), 32'd2);
        check("lw_rdata", rd_v, 32'hDEADBEEF);
        xact(0, 0, 1, 3'b000, 32'h11, 32'h00000080, lat, rd_v, er_v, t0);
        check("sb_err", 32'(er_v), 32'd0);
        xact(0, 1, 0, 3'b010, 32'h10, 32'h0, lat, rd_v, er_v, t0);
        check("lw_after_sb", rd_v, 32'hDEAD80EF);
        xact(0, 1, 0, 3'b000, 32'h11, 32'h0, lat, rd_v, er_v, t0);
        check("lb", rd_v, 32'hFFFFFF80);
        xact(0, 1, 0, 3'b100, 32'h11, 32'h0, lat, rd_v, er_v, t0);
        check("lbu", rd_v, 32'h00000080);
        xact(0, 1, 0, 3'b001, 32'h12, 32'h0, lat, rd_v, er_v, t0);
        check("lh", rd_v, 32'hFFFFDEAD);
        xact(0, 1, 0, 3'b101, 32'h12, 32'h0, lat, rd_v, er_v, t0);
        check("lhu", rd_v, 32'h0000DEAD);
        xact(0, 0, 1, 3'b001, 32'h12, 32'h0000BEEF, lat, rd_v, er_v, t0);
        xact(0, 1, 0, 3'b010, 32'h10, 32'h0, lat, rd_v, er_v, t0);
        check("lw_after_sh", rd_v, 32'hBEEF80EF);

        xact(0, 1, 0, 3'b010, 32'h13, 32'h0, lat, rd_v, er_v, t0);
        check("lw_mis_err", 32'(er_v), 32'd1);
        check("lw_mis_rdata", rd_v, 32'd0);
        check("lw_mis_lat", 32'(lat), 32'd2);
        xact(0, 0, 1, 3'b010, 32'h20, 32'h11223344, lat, rd_v, er_v, t0);
        xact(0, 0, 1, 3'b001, 32'h21, 32'h0000AAAA, lat, rd_v, er_v, t0);
        check("sh_mis_err", 32'(er_v), 32'd1);
        xact(0, 1, 0, 3'b010, 32'h20, 32'h0, lat, rd_v, er_v, t0);
        check("sh_mis_nowrite", rd_v, 32'h11223344);
        xact(0, 1, 0, 3'b010, 32'h400, 32'h0, lat, rd_v, er_v, t0);
        check("range_err", 32'(er_v), 32'd1);
        xact(0, 1, 1, 3'b010, 32'h20, 32'h0, lat, rd_v, er_v, t0);
        check("rdwr_err", 32'(er_v), 32'd1);
        xact(0, 0, 0, 3'b010, 32'h20, 32'h0, lat, rd_v, er_v, t0);
        check("none_err", 32'(er_v), 32'd1);
        xact(0, 1, 0, 3'b011, 32'h20, 32'h0, lat, rd_v, er_v, t0);
        check("f3_err", 32'(er_v), 32'd1);
        xact(0, 0, 1, 3'b100, 32'h20, 32'h0, lat, rd_v, er_v, t0);
        check("st_f3_err", 32'(er_v), 32'd1);
        xact(0, 1, 0, 3'b010, 32'h20, 32'h0, lat, rd_v, er_v, t0);
        check("st_f3_nowrite", rd_v, 32'h11223344);

        // Backpressure: response held for 5 cycles.
        rsp_ready = 1'b0;
        sel = 0; mem_read = 1; mem_write = 0; funct3 = 3'b010; addr = 32'h10;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        for (int i = 0; i < 5; i++) begin
            check("bp_valid", 32'(rsp_valid), 32'd1);
            check("bp_rdata", rsp_rdata, 32'hBEEF80EF);
            check("bp_err", 32'(rsp_err), 32'd0);
            check("bp_req_ready", 32'(req_ready), 32'd0);
            @(posedge clk); #1;
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_retire_valid", 32'(rsp_valid), 32'd0);
        check("bp_retire_rdata", rsp_rdata, 32'd0);
        check("bp_retire_ready", 32'(req_ready), 32'd1);

        // Latency 4 instance: reset aborts an uncommitted store.
        xact(1, 0, 1, 3'b010, 32'h40, 32'hCAFEF00D, lat, rd_v, er_v, t0);
        check("l4_sw_lat", 32'(lat), 32'd4);
        sel = 1; mem_read = 0; mem_write = 1; funct3 = 3'b010; addr = 32'h40; wdata = 32'h12345678;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        #1;
        check("abort_rst_ready", 32'(req_ready), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (rsp_valid) seen = 1'b1;
        end
        check("abort_no_rsp", 32'(seen), 32'd0);
        xact(1, 1, 0, 3'b010, 32'h40, 32'h0, lat, rd_v, er_v, t0);
        check("abort_old_data", rd_v, 32'hCAFEF00D);

        // Latency 1 instance: back-to-back loads every 3 cycles.
        xact(2, 0, 1, 3'b010, 32'h0, 32'hA5A55A5A, lat, rd_v, er_v, t0);
        check("l1_sw_lat", 32'(lat), 32'd1);
        xact(2, 1, 0, 3'b010, 32'h0, 32'h0, lat, rd_v, er_v, t0);
        check("l1_lat0", 32'(lat), 32'd1);
        check("l1_rdata0", rd_v, 32'hA5A55A5A);
        xact(2, 1, 0, 3'b000, 32'h0, 32'h0, lat, rd_v, er_v, t1);
        check("l1_lat1", 32'(lat), 32'd1);
        check("l1_rdata1", rd_v, 32'h0000005A);
        xact(2, 1, 0, 3'b000, 32'h3, 32'h0, lat, rd_v, er_v, t2);
        check("l1_rdata2", rd_v, 32'hFFFFFFA5);
        check("l1_gap01", 32'(t1 - t0), 32'd30);
        check("l1_gap12", 32'(t2 - t1), 32'd30);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
